// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: RV M-extension multiply/divide unit; start/op/a/b in, flush aborts, stall/busy/done/result out
module ex_muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [2:0] op_q;
  logic [XLEN-1:0] a_q, b_q, rem, quo, dvs, rem_n, quo_n, q_fin, r_fin, div_res;
  logic [XLEN-1:0] m_a, m_b, mul_res, a_mag, b_mag, fast_res, min_v;
  logic [2:0] m_op;
  logic [2*XLEN-1:0] ax, bx, prod;
  logic [XLEN:0] sh, diff;
  logic [5:0] cnt;
  logic neg_q, neg_r, a_neg, b_neg, d_sgn, div0, ovf, ge;
  always_comb begin
    m_op = state == IDLE ? op : op_q;
    m_a = state == IDLE ? a : a_q;
    m_b = state == IDLE ? b : b_q;
    ax = {{XLEN{m_op[1:0] != 2'b11 && m_a[XLEN-1]}}, m_a};
    bx = {{XLEN{!m_op[1] && m_b[XLEN-1]}}, m_b};
    prod = ax * bx;
    mul_res = m_op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    min_v = {1'b1, {(XLEN-1){1'b0}}};
    d_sgn = !op[0];
    a_neg = d_sgn && a[XLEN-1];
    b_neg = d_sgn && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    div0 = b == '0;
    ovf = d_sgn && a == min_v && b == '1;
    fast_res = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : min_v);
    sh = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    ge = !diff[XLEN];
    rem_n = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    quo_n = {quo[XLEN-2:0], ge};
    q_fin = neg_q ? -quo_n : quo_n;
    r_fin = neg_r ? -rem_n : rem_n;
    div_res = op_q[1] ? r_fin : q_fin;
  end
  assign busy = !rst && state != IDLE;
  assign stall = !rst && ((state == IDLE && start && !flush) || state == MUL || state == DIV);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      result <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !flush) begin
          op_q <= op;
          a_q <= a;
          b_q <= b;
          if (!op[2]) begin
            if (MUL_LAT == 1) begin
              state <= DONE;
              done <= 1'b1;
              result <= mul_res;
            end else begin
              state <= MUL;
              cnt <= 6'd1;
            end
          end else if (div0 || ovf) begin
            state <= DONE;
            done <= 1'b1;
            result <= fast_res;
          end else begin
            state <= DIV;
            cnt <= '0;
            rem <= '0;
            quo <= a_mag;
            dvs <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        MUL: if (flush) state <= IDLE;
        else if (cnt == 6'(MUL_LAT - 1)) begin
          state <= DONE;
          done <= 1'b1;
          result <= mul_res;
        end else cnt <= cnt + 6'd1;
        DIV: if (flush) state <= IDLE;
        else begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(XLEN - 1)) begin
            state <= DONE;
            done <= 1'b1;
            result <= div_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
